// File: rtl/adsr_pkg.sv
// ----------------------------------------------------------------------------
// adsr_pkg: shared constants for the ADSR envelope generator.
//   ST_*      : FSM state codes (IDLE=0 .. RELEASE=4, codes 5-7 unused)
//   LEVEL_W   : width of the level accumulator
//   LEVEL_MAX : attack ceiling
//   SUS_SHIFT : left shift that turns the 7-bit sustain control into a level
// ----------------------------------------------------------------------------
package adsr_pkg;

  localparam int unsigned LEVEL_W   = 32;
  localparam int unsigned SUS_SHIFT = 25;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 32'hFFFF_FFFF;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // Sustain control scaled to a full-width level: {sustain, 25'b0}.
  function automatic logic [LEVEL_W-1:0] sus_level(input logic [6:0] sustain);
    return {sustain, {SUS_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/env_step.sv
// ----------------------------------------------------------------------------
// env_step: one saturating envelope step, purely combinational.
//   level      in  current level
//   rate       in  per-tick step size
//   target     in  level at which the segment ends (ceiling when rising,
//                  floor when falling)
//   dir        in  1 = add (ATTACK), 0 = subtract (DECAY / RELEASE)
//   next_level out stepped level, clamped to target once reached
//   reached    out segment has hit or passed its target this step
// ----------------------------------------------------------------------------
module env_step
  import adsr_pkg::*;
(
  input  logic [LEVEL_W-1:0] level,
  input  logic [LEVEL_W-1:0] rate,
  input  logic [LEVEL_W-1:0] target,
  input  logic               dir,
  output logic [LEVEL_W-1:0] next_level,
  output logic               reached
);

  // 33-bit arithmetic: bit 32 is the carry (add) or the borrow (subtract).
  logic [LEVEL_W:0] sum;
  logic [LEVEL_W:0] diff;

  assign sum  = {1'b0, level} + {1'b0, rate};
  assign diff = {1'b0, level} - {1'b0, rate};

  // Rising: done on overflow or on landing exactly on the ceiling.
  // Falling: done on underflow or on landing at/below the floor; with a
  // floor of 0 the compare reduces to "diff == 0".
  always_comb begin
    if (dir) begin
      reached = sum[LEVEL_W] || (sum[LEVEL_W-1:0] >= target);
    end else begin
      reached = diff[LEVEL_W] || (diff[LEVEL_W-1:0] <= target);
    end
  end

  assign next_level = reached ? target
                    : (dir ? sum[LEVEL_W-1:0] : diff[LEVEL_W-1:0]);

endmodule

// File: rtl/adsr_env_gen.sv
// ----------------------------------------------------------------------------
// adsr_env_gen: per-voice ADSR envelope generator.
//   clk, rst_n    clock, asynchronous active-low reset
//   tick          sample-rate strobe (one clk wide); level steps only on tick
//   gate          note gate; rise -> ATTACK (legato, level kept),
//                 fall -> RELEASE from ATTACK/DECAY/SUSTAIN
//   attack_rate   per-tick increment in ATTACK
//   decay_rate    per-tick decrement in DECAY
//   release_rate  per-tick decrement in RELEASE
//   sustain       sustain control, level = {sustain, 25'b0}
//   velocity      note velocity, only used when ADSR_VEL_EN is defined
//   env_out       top OUT_W bits of the level (velocity-scaled and one clk
//                 later when ADSR_VEL_EN is defined)
//   env_state     current state code
//   busy          state != IDLE
// Optional build macro: ADSR_VEL_EN (velocity scaling of env_out).
// ----------------------------------------------------------------------------
module adsr_env_gen
  import adsr_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             gate,
  input  logic [31:0]      attack_rate,
  input  logic [31:0]      decay_rate,
  input  logic [31:0]      release_rate,
  input  logic [6:0]       sustain,
  input  logic [6:0]       velocity,
  output logic [OUT_W-1:0] env_out,
  output logic [2:0]       env_state,
  output logic             busy
);

  logic [2:0]         state, state_nxt;
  logic [LEVEL_W-1:0] level, level_nxt;
  logic               gate_q;
  logic               busy_q;

  logic               rise, fall;
  logic [LEVEL_W-1:0] sus;
  logic [LEVEL_W-1:0] step_rate, step_target, step_level;
  logic               step_up, step_reached;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;
  assign sus  = sus_level(sustain);

  // One stepper serves all three moving segments.
  always_comb begin
    step_up     = 1'b0;
    step_rate   = release_rate;
    step_target = '0;
    case (state)
      ST_ATTACK: begin
        step_up     = 1'b1;
        step_rate   = attack_rate;
        step_target = LEVEL_MAX;
      end
      ST_DECAY: begin
        step_rate   = decay_rate;
        step_target = sus;
      end
      default: ;
    endcase
  end

  env_step u_step (
    .level      (level),
    .rate       (step_rate),
    .target     (step_target),
    .dir        (step_up),
    .next_level (step_level),
    .reached    (step_reached)
  );

  // Edges beat ticks: on an edge cycle only the state moves.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    state_nxt = state;
    level_nxt = level;
    if (rise) begin
      state_nxt = ST_ATTACK;
    end else if (fall && (state == ST_ATTACK || state == ST_DECAY ||
                          state == ST_SUSTAIN)) begin
      state_nxt = ST_RELEASE;
    end else begin
      case (state)
        ST_IDLE: level_nxt = '0;
        ST_ATTACK, ST_DECAY, ST_RELEASE: begin
          if (tick) begin
            level_nxt = step_level;
            if (step_reached) begin
              case (state)
                ST_ATTACK: state_nxt = ST_DECAY;
                ST_DECAY:  state_nxt = ST_SUSTAIN;
                default:   state_nxt = ST_IDLE;
              endcase
            end
          end
        end
        ST_SUSTAIN: if (tick) level_nxt = sus;
        default: begin
          // Unreachable codes 5-7: fall back to a clean idle.
          state_nxt = ST_IDLE;
          level_nxt = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      level  <= '0;
      gate_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      level  <= level_nxt;
      gate_q <= gate;
      busy_q <= (state_nxt != ST_IDLE);
    end
  end

  assign env_state = state;
  assign busy      = busy_q;

`ifdef ADSR_VEL_EN
  // Velocity captured per note; scale factor is (vel_q + 1) / 128 so that
  // velocity 127 passes the level through unchanged.
  logic [6:0]       vel_q;
  logic [OUT_W-1:0] env_q;
  logic [7:0]       vel_p1;
  logic [OUT_W+7:0] prod;
  logic             unused_prod_bits;

  assign vel_p1 = {1'b0, vel_q} + 8'd1;
  assign prod   = {8'd0, level[31 -: OUT_W]} * {{OUT_W{1'b0}}, vel_p1};
  assign unused_prod_bits = ^{prod[OUT_W+7], prod[6:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vel_q <= '0;
      env_q <= '0;
    end else begin
      if (rise) vel_q <= velocity;
      env_q <= prod[OUT_W+6:7];
    end
  end

  assign env_out = env_q;
`else
  logic unused_velocity;
  assign unused_velocity = ^velocity;

  assign env_out = level[31 -: OUT_W];
`endif

endmodule

// File: tb/tb_adsr_env_gen.sv
module tb_adsr_env_gen;

  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tick;
  logic             gate;
  logic [31:0]      attack_rate, decay_rate, release_rate;
  logic [6:0]       sustain, velocity;
  logic [OUT_W-1:0] env_out;
  logic [2:0]       env_state;
  logic             busy;

  int checks = 0;
  int passed = 0;

  adsr_env_gen #(.OUT_W(OUT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .gate         (gate),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .release_rate (release_rate),
    .sustain      (sustain),
    .velocity     (velocity),
    .env_out      (env_out),
    .env_state    (env_state),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: level as a wide signed number, segment end decided by
  // plain comparisons against the ceiling / floor.
  typedef enum int {P_IDLE = 0, P_ATTACK = 1, P_DECAY = 2,
                    P_SUSTAIN = 3, P_RELEASE = 4} phase_t;
  localparam longint TOP = 64'h0000_0000_FFFF_FFFF;

  phase_t m_phase;
  longint m_level;
  bit     m_gate_prev;

  function automatic void model_reset();
    m_phase     = P_IDLE;
    m_level     = 0;
    m_gate_prev = 1'b0;
  endfunction

  function automatic void model_clk();
    longint floor_lvl;
    longint v;
    bit     went_up, went_down;
    went_up     = gate && !m_gate_prev;
    went_down   = !gate && m_gate_prev;
    m_gate_prev = gate;
    floor_lvl   = longint'(sustain) * 64'd33554432;
    if (went_up) begin
      m_phase = P_ATTACK;
    end else if (went_down && (m_phase == P_ATTACK || m_phase == P_DECAY ||
                               m_phase == P_SUSTAIN)) begin
      m_phase = P_RELEASE;
    end else if (tick) begin
      case (m_phase)
        P_ATTACK: begin
          v = m_level + longint'(attack_rate);
          if (v >= TOP) begin m_level = TOP; m_phase = P_DECAY; end
          else m_level = v;
        end
        P_DECAY: begin
          v = m_level - longint'(decay_rate);
          if (v <= floor_lvl) begin m_level = floor_lvl; m_phase = P_SUSTAIN; end
          else m_level = v;
        end
        P_SUSTAIN: m_level = floor_lvl;
        P_RELEASE: begin
          v = m_level - longint'(release_rate);
          if (v <= 0) begin m_level = 0; m_phase = P_IDLE; end
          else m_level = v;
        end
        default: m_level = 0;
      endcase
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_out;
    exp_out = 32'(m_level >> (32 - OUT_W));
    check({tag, ".env_out"}, 32'(env_out), exp_out);
    check({tag, ".state"}, 32'(env_state), 32'(int'(m_phase)));
    check({tag, ".busy"}, 32'(busy), 32'(m_phase != P_IDLE));
  endtask

  // One clk: drive on the falling edge, model the rising edge, sample 1ns later.
  task automatic cyc(input logic t, input logic g);
    @(negedge clk);
    tick = t;
    gate = g;
    @(posedge clk);
    model_clk();
    #1;
    check_model("cyc");
  endtask

  initial begin
    logic g;
    rst_n        = 1'b0;
    tick         = 1'b0;
    gate         = 1'b0;
    attack_rate  = 32'h4000_0000;
    decay_rate   = 32'h1000_0000;
    release_rate = 32'h2000_0000;
    sustain      = 7'd64;
    velocity     = 7'd127;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.env_out", 32'(env_out), 32'h0);
    check("rst.state", 32'(env_state), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Attack then decay; rise coincides with a tick so level stays 0
    cyc(1'b1, 1'b1);
    check("rise_tick.state", 32'(env_state), 32'd1);
    check("rise_tick.level", 32'(env_out), 32'h0000);
    cyc(1'b1, 1'b1); check("att1", 32'(env_out), 32'h4000);
    cyc(1'b1, 1'b1); check("att2", 32'(env_out), 32'h8000);
    cyc(1'b1, 1'b1); check("att3", 32'(env_out), 32'hC000);
    cyc(1'b1, 1'b1);
    check("att4.out", 32'(env_out), 32'hFFFF);
    check("att4.state", 32'(env_state), 32'd2);
    cyc(1'b1, 1'b1); check("dec1", 32'(env_out), 32'hEFFF);
    for (int i = 2; i <= 7; i++) cyc(1'b1, 1'b1);
    check("dec7", 32'(env_out), 32'h8FFF);
    cyc(1'b1, 1'b1);
    check("dec8.out", 32'(env_out), 32'h8000);
    check("dec8.state", 32'(env_state), 32'd3);

    // Gate held, no tick: frozen
    repeat (4) cyc(1'b0, 1'b1);
    check("frozen", 32'(env_out), 32'h8000);

    // Live sustain follow, then back to 64
    sustain = 7'd32;
    cyc(1'b1, 1'b1); check("sus32", 32'(env_out), 32'h4000);
    sustain = 7'd64;
    cyc(1'b1, 1'b1); check("sus64", 32'(env_out), 32'h8000);

    // Release to idle: edge cycle keeps the level
    cyc(1'b1, 1'b0);
    check("rel.state", 32'(env_state), 32'd4);
    check("rel.hold", 32'(env_out), 32'h8000);
    cyc(1'b1, 1'b0); check("rel1", 32'(env_out), 32'h6000);
    cyc(1'b1, 1'b0); check("rel2", 32'(env_out), 32'h4000);
    cyc(1'b1, 1'b0); check("rel3", 32'(env_out), 32'h2000);
    cyc(1'b1, 1'b0);
    check("rel4.out", 32'(env_out), 32'h0);
    check("rel4.state", 32'(env_state), 32'd0);
    check("rel4.busy", 32'(busy), 32'd0);

    // Early release after two attack ticks, then legato retrigger
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1); check("early.att2", 32'(env_out), 32'h8000);
    cyc(1'b1, 1'b0);
    check("early.state", 32'(env_state), 32'd4);
    check("early.hold", 32'(env_out), 32'h8000);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0); check("early.rel", 32'(env_out), 32'h4000);
    cyc(1'b1, 1'b1);
    check("retrig.state", 32'(env_state), 32'd1);
    check("retrig.level", 32'(env_out), 32'h4000);
    cyc(1'b1, 1'b1); check("retrig.att", 32'(env_out), 32'h8000);

    // Drain to idle, then stall attack with rate 0
    cyc(1'b0, 1'b0);
    release_rate = 32'hFFFF_FFFF;
    cyc(1'b1, 1'b0);
    check("drain", 32'(env_state), 32'd0);
    release_rate = 32'h2000_0000;
    attack_rate  = 32'h0;
    cyc(1'b1, 1'b1);
    repeat (100) cyc(1'b1, 1'b1);
    check("stall.state", 32'(env_state), 32'd1);
    check("stall.level", 32'(env_out), 32'h0);

    // sustain=0 ends decay at level 0 in SUSTAIN, not IDLE
    attack_rate = 32'h8000_0000;
    sustain     = 7'd0;
    decay_rate  = 32'h7000_0000;
    repeat (6) cyc(1'b1, 1'b1);
    check("sus0.state", 32'(env_state), 32'd3);
    check("sus0.level", 32'(env_out), 32'h0);
    sustain = 7'd64;

    // Reset mid-decay, asynchronously between edges
    cyc(1'b0, 1'b0);
    release_rate = 32'hFFFF_FFFF;
    cyc(1'b1, 1'b0);
    release_rate = 32'h2000_0000;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    check("pre_rst.state", 32'(env_state), 32'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.env_out", 32'(env_out), 32'h0);
    check("arst.state", 32'(env_state), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    gate = 1'b1;
    tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1);
    check("post_rst.state", 32'(env_state), 32'd1);

    // Randomized run against the model
    g = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        attack_rate  = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 12));
        decay_rate   = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 12));
        release_rate = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 12));
        sustain      = 7'($urandom_range(0, 127));
        velocity     = 7'($urandom_range(0, 127));
      end
      if ($urandom_range(0, 29) == 0) g = ~g;
      cyc(1'($urandom_range(0, 3) != 0), g);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
